// File: rtl/logic_unit_pipe_pkg.sv
// rtl/logic_unit_pipe_pkg.sv - op codes and flag bundle shared by the logic unit pipeline
package logic_unit_pipe_pkg;

  typedef enum logic [2:0] {
    LU_AND   = 3'd0,
    LU_OR    = 3'd1,
    LU_XOR   = 3'd2,
    LU_NAND  = 3'd3,
    LU_NOR   = 3'd4,
    LU_XNOR  = 3'd5,
    LU_NOTA  = 3'd6,
    LU_PASSA = 3'd7
  } lu_op_e;

  typedef struct packed {
    logic zero;
    logic parity;
    logic ones;
  } lu_flags_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle for the logic unit pipeline
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic             ones;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, parity, ones
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, parity, ones
  );
endinterface

// File: rtl/xor_reduce.sv
// rtl/xor_reduce.sv - combinational XOR tree; 1 = odd number of ones in data_i
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage bitwise logic unit with registered zero/parity/ones flags
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave lu
);

  logic             adv1;
  logic             adv2;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] y_q, y_d;
  lu_flags_t        flags_q, flags_d;
  lu_flags_t        r1_flags;
  logic [WIDTH-1:0] op_res;
  logic             r1_parity;
  lu_op_e           op_sel;

  assign op_sel = lu_op_e'(lu.op);

  always_comb begin
    op_res = lu.a;
    case (op_sel)
      LU_AND:   op_res = lu.a & lu.b;
      LU_OR:    op_res = lu.a | lu.b;
      LU_XOR:   op_res = lu.a ^ lu.b;
      LU_NAND:  op_res = ~(lu.a & lu.b);
      LU_NOR:   op_res = ~(lu.a | lu.b);
      LU_XNOR:  op_res = ~(lu.a ^ lu.b);
      LU_NOTA:  op_res = ~lu.a;
      LU_PASSA: op_res = lu.a;
      default:  op_res = lu.a;
    endcase
  end

  // No skid buffer: a stall at the consumer ripples straight back to in_ready.
  assign adv2 = !s2_v_q || lu.out_ready;
  assign adv1 = !s1_v_q || adv2;

  xor_reduce #(.WIDTH(WIDTH)) u_parity (
    .data_i  (r1_q),
    .parity_o(r1_parity)
  );

  always_comb begin
    r1_flags.zero   = (r1_q == '0);
    r1_flags.parity = r1_parity;
    r1_flags.ones   = (r1_q == '1);
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    r1_d    = r1_q;
    s2_v_d  = s2_v_q;
    y_d     = y_q;
    flags_d = flags_q;
    if (adv1) begin
      s1_v_d = lu.in_valid;
      if (lu.in_valid) r1_d = op_res;
    end
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        y_d     = r1_q;
        flags_d = r1_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      r1_q    <= '0;
      s2_v_q  <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      r1_q    <= r1_d;
      s2_v_q  <= s2_v_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign lu.in_ready  = adv1;
  assign lu.out_valid = s2_v_q;
  assign lu.y         = y_q;
  assign lu.zero      = flags_q.zero;
  assign lu.parity    = flags_q.parity;
  assign lu.ones      = flags_q.ones;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed bench for logic_unit_pipe at WIDTH=8 and WIDTH=1
module tb_logic_unit_pipe;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  logic_unit_pipe_if #(.WIDTH(8)) bus8 ();
  logic_unit_pipe_if #(.WIDTH(1)) bus1 ();

  logic_unit_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .lu(bus8));
  logic_unit_pipe #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .lu(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [2:0] s_op [0:31];
  logic [7:0] s_a  [0:31];
  logic [7:0] s_b  [0:31];
  logic [7:0] e_y  [0:31];
  logic       e_z  [0:31];
  logic       e_p  [0:31];
  logic       e_o  [0:31];

  logic [7:0] tt8 [0:7] = '{8'hA0, 8'hFA, 8'h5A, 8'h5F, 8'h05, 8'hA5, 8'h0F, 8'hF0};
  // Bit {a,b} of each row is the 1-bit result for that operand pair.
  logic [3:0] tt1 [0:7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                            4'b0001, 4'b1001, 4'b0011, 4'b1100};

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void set_beat(int i, logic [2:0] op, logic [7:0] a, logic [7:0] b,
                                   logic [7:0] y);
    s_op[i] = op;
    s_a[i]  = a;
    s_b[i]  = b;
    e_y[i]  = y;
    e_z[i]  = (y == 8'h00);
    e_p[i]  = ($countones(y) % 2) == 1;
    e_o[i]  = (y == 8'hFF);
  endfunction

  task automatic drive8(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    bus8.in_valid = 1'b1;
    bus8.op       = op;
    bus8.a        = a;
    bus8.b        = b;
  endtask

  // Streams n beats back-to-back with out_ready high; expects an empty pipe on entry.
  task automatic stream8(string name, int n);
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        chk1($sformatf("%s out_valid %0d", name, k - 2), bus8.out_valid, 1'b1);
        chk8($sformatf("%s y %0d", name, k - 2), bus8.y, e_y[k-2]);
        chk1($sformatf("%s zero %0d", name, k - 2), bus8.zero, e_z[k-2]);
        chk1($sformatf("%s parity %0d", name, k - 2), bus8.parity, e_p[k-2]);
        chk1($sformatf("%s ones %0d", name, k - 2), bus8.ones, e_o[k-2]);
      end else begin
        chk1($sformatf("%s latency out_valid %0d", name, k), bus8.out_valid, 1'b0);
      end
      if (k < n) drive8(s_op[k], s_a[k], s_b[k]);
      else bus8.in_valid = 1'b0;
      #1;
      if (k < n) chk1($sformatf("%s in_ready %0d", name, k), bus8.in_ready, 1'b1);
    end
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.op        = 3'd0;
    bus8.a         = 8'h00;
    bus8.b         = 8'h00;
    bus8.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.op        = 3'd0;
    bus1.a         = 1'b0;
    bus1.b         = 1'b0;
    bus1.out_ready = 1'b1;

    @(posedge clk); #1;
    chk1("reset out_valid", bus8.out_valid, 1'b0);
    chk8("reset y", bus8.y, 8'h00);
    chk1("reset zero", bus8.zero, 1'b0);
    chk1("reset parity", bus8.parity, 1'b0);
    chk1("reset ones", bus8.ones, 1'b0);
    chk1("reset in_ready", bus8.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) set_beat(i, 3'(i), 8'hF0, 8'hAA, tt8[i]);
    stream8("sweep", 8);

    set_beat(0, 3'd2, 8'h3C, 8'h3C, 8'h00);
    set_beat(1, 3'd1, 8'hFF, 8'h00, 8'hFF);
    set_beat(2, 3'd7, 8'h01, 8'h55, 8'h01);
    e_z[0] = 1'b1; e_p[0] = 1'b0; e_o[0] = 1'b0;
    e_z[1] = 1'b0; e_p[1] = 1'b0; e_o[1] = 1'b1;
    e_z[2] = 1'b0; e_p[2] = 1'b1; e_o[2] = 1'b0;
    stream8("flags", 3);

    for (int i = 0; i < 16; i++) set_beat(i, 3'd2, 8'(i * 17), 8'h5A, 8'(i * 17) ^ 8'h5A);
    stream8("b2b", 16);

    // Backpressure: out_ready low across five edges while three beats are offered.
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    drive8(3'd0, 8'hFF, 8'h0F);
    #1 chk1("bp in_ready 0", bus8.in_ready, 1'b1);
    @(posedge clk); #1;
    chk1("bp out_valid early", bus8.out_valid, 1'b0);
    drive8(3'd1, 8'h10, 8'h01);
    #1 chk1("bp in_ready 1", bus8.in_ready, 1'b1);
    @(posedge clk); #1;
    drive8(3'd2, 8'h33, 8'h0F);
    #1 chk1("bp in_ready full", bus8.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk1($sformatf("bp hold in_ready %0d", i), bus8.in_ready, 1'b0);
      chk1($sformatf("bp hold out_valid %0d", i), bus8.out_valid, 1'b1);
      chk8($sformatf("bp hold y %0d", i), bus8.y, 8'h0F);
      chk1($sformatf("bp hold zero %0d", i), bus8.zero, 1'b0);
      chk1($sformatf("bp hold parity %0d", i), bus8.parity, 1'b0);
      chk1($sformatf("bp hold ones %0d", i), bus8.ones, 1'b0);
    end
    @(posedge clk); #1;
    chk8("bp pre-release y", bus8.y, 8'h0F);
    bus8.out_ready = 1'b1;
    #1 chk1("bp release in_ready", bus8.in_ready, 1'b1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    chk1("bp drain1 out_valid", bus8.out_valid, 1'b1);
    chk8("bp drain1 y", bus8.y, 8'h11);
    @(posedge clk); #1;
    chk1("bp drain2 out_valid", bus8.out_valid, 1'b1);
    chk8("bp drain2 y", bus8.y, 8'h3C);
    chk1("bp drain2 parity", bus8.parity, 1'b0);
    @(posedge clk); #1;
    chk1("bp empty out_valid", bus8.out_valid, 1'b0);

    // Reset while both stages hold beats.
    bus8.out_ready = 1'b0;
    drive8(3'd7, 8'hFF, 8'h00);
    @(posedge clk); #1;
    drive8(3'd7, 8'h01, 8'h00);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    chk8("rs stall y", bus8.y, 8'hFF);
    chk1("rs stall ones", bus8.ones, 1'b1);
    chk1("rs stall in_ready", bus8.in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("rs async out_valid", bus8.out_valid, 1'b0);
    chk8("rs async y", bus8.y, 8'h00);
    chk1("rs async zero", bus8.zero, 1'b0);
    chk1("rs async parity", bus8.parity, 1'b0);
    chk1("rs async ones", bus8.ones, 1'b0);
    chk1("rs async in_ready", bus8.in_ready, 1'b1);
    @(posedge clk); #1;
    chk1("rs held out_valid", bus8.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("rs no stale %0d", i), bus8.out_valid, 1'b0);
    end
    set_beat(0, 3'd2, 8'h0F, 8'hFF, 8'hF0);
    stream8("post-reset", 1);

    // WIDTH=1: every op against every operand pair, streamed back-to-back.
    for (int j = 0; j < 34; j++) begin
      @(posedge clk); #1;
      if (j >= 2) begin
        logic [3:0] row;
        logic       ey;
        row = tt1[(j - 2) / 4];
        ey  = row[(j - 2) % 4];
        chk1($sformatf("w1 out_valid %0d", j - 2), bus1.out_valid, 1'b1);
        chk1($sformatf("w1 y %0d", j - 2), bus1.y, ey);
        chk1($sformatf("w1 zero %0d", j - 2), bus1.zero, ~ey);
        chk1($sformatf("w1 ones %0d", j - 2), bus1.ones, ey);
        chk1($sformatf("w1 parity %0d", j - 2), bus1.parity, ey);
      end
      if (j < 32) begin
        bus1.in_valid = 1'b1;
        bus1.op       = 3'(j / 4);
        bus1.a        = ((j % 4) >= 2);
        bus1.b        = ((j % 2) == 1);
        #1 chk1($sformatf("w1 in_ready %0d", j), bus1.in_ready, 1'b1);
      end else begin
        bus1.in_valid = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
